// File: rtl/mem_march_bist_if.sv
// Single read/write port between the BIST sequencer and the memory macro.
// mem_rdata returns the word addressed by a read strobe one cycle later.
interface mem_march_bist_if #(
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned DATA_BITS = 8
);
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_we;
  logic                 mem_re;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [DATA_BITS-1:0] mem_rdata;

  // BIST drives the port
  modport master (
    output mem_addr,
    output mem_we,
    output mem_re,
    output mem_wdata,
    input  mem_rdata
  );

  // Memory answers on the port
  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_re,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_march_bist.sv
// March C- BIST sequencer. Takes over the memory port on a start pulse, walks
// E0..E5 one op per cycle, compares each read on the following cycle, and
// reports pass/fail, the first failing address/element and a saturating
// mismatch count.
module mem_march_bist #(
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CNT_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DATA_BITS-1:0] bg,
  mem_march_bist_if.master     mem,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [ADDR_BITS-1:0] fail_addr,
  output logic [2:0]           fail_elem,
  output logic [CNT_BITS-1:0]  err_count
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  localparam logic [ADDR_BITS-1:0] AddrMax = '1;
  localparam logic [ADDR_BITS-1:0] AddrOne = 1;
  localparam logic [CNT_BITS-1:0]  CntMax  = '1;
  localparam logic [CNT_BITS-1:0]  CntOne  = 1;

  state_e               state_q;
  logic [DATA_BITS-1:0] bg_q;
  logic [2:0]           elem_q;
  // The registered port outputs double as the march position: addr_q is the
  // address counter and we_q/re_q tell which half of an element we are in.
  logic [ADDR_BITS-1:0] addr_q;
  logic                 we_q;
  logic                 re_q;
  logic [DATA_BITS-1:0] wdata_q;

  logic                 cmp_valid_q;
  logic [DATA_BITS-1:0] cmp_exp_q;
  logic [ADDR_BITS-1:0] cmp_addr_q;
  logic [2:0]           cmp_elem_q;

  logic                 down;
  logic                 at_term;
  logic [2:0]           nxt_elem;
  logic [ADDR_BITS-1:0] nxt_addr;
  logic                 nxt_we;
  logic                 nxt_end;
  logic [DATA_BITS-1:0] nxt_wdata;
  logic [DATA_BITS-1:0] rd_exp;
  logic                 mismatch;

  assign mem.mem_addr  = addr_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_re    = re_q;
  assign mem.mem_wdata = wdata_q;

  // Next march position and the data patterns for the current/next op
  always_comb begin
    down      = (elem_q == 3'd3) || (elem_q == 3'd4);
    at_term   = down ? (addr_q == '0) : (addr_q == AddrMax);
    nxt_elem  = elem_q;
    nxt_addr  = addr_q;
    nxt_we    = 1'b0;
    nxt_end   = 1'b0;
    if (re_q && (elem_q != 3'd5)) begin
      // read half of a read-then-write element: write the same address next
      nxt_we = 1'b1;
    end else if (at_term) begin
      if (elem_q == 3'd5) begin
        nxt_end = 1'b1;
      end else begin
        // every element after E0 opens with a read; E3/E4 walk downwards
        nxt_elem = elem_q + 3'd1;
        nxt_addr = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? AddrMax : '0;
      end
    end else begin
      nxt_addr = down ? (addr_q - AddrOne) : (addr_q + AddrOne);
      nxt_we   = (elem_q == 3'd0);
    end
    nxt_wdata = ((nxt_elem == 3'd1) || (nxt_elem == 3'd3)) ? ~bg_q : bg_q;
    rd_exp    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~bg_q : bg_q;
    mismatch  = cmp_valid_q && (mem.mem_rdata != cmp_exp_q);
  end

  // Sequencer FSM, port outputs, compare pipeline and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bg_q        <= '0;
      elem_q      <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      wdata_q     <= '0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      fail_addr   <= '0;
      fail_elem   <= '0;
      err_count   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_q     <= StRun;
            bg_q        <= bg;
            elem_q      <= '0;
            addr_q      <= '0;
            we_q        <= 1'b1;
            re_q        <= 1'b0;
            wdata_q     <= bg;
            cmp_valid_q <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            fail        <= 1'b0;
            fail_addr   <= '0;
            fail_elem   <= '0;
            err_count   <= '0;
          end
        end
        StRun, StFlush: begin
          if (abort) begin
            // drop whatever compare is in flight; results so far are kept
            state_q     <= StIdle;
            elem_q      <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            wdata_q     <= '0;
            cmp_valid_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
          end else begin
            if (mismatch) begin
              if (err_count != CntMax) err_count <= err_count + CntOne;
              if (!fail) begin
                fail      <= 1'b1;
                fail_addr <= cmp_addr_q;
                fail_elem <= cmp_elem_q;
              end
            end
            cmp_valid_q <= re_q;
            cmp_exp_q   <= rd_exp;
            cmp_addr_q  <= addr_q;
            cmp_elem_q  <= elem_q;
            if (state_q == StFlush) begin
              state_q <= StIdle;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (nxt_end) begin
              // last E5 read issued; one more cycle to compare its data
              state_q <= StFlush;
              elem_q  <= '0;
              addr_q  <= '0;
              we_q    <= 1'b0;
              re_q    <= 1'b0;
              wdata_q <= '0;
            end else begin
              elem_q  <= nxt_elem;
              addr_q  <= nxt_addr;
              we_q    <= nxt_we;
              re_q    <= !nxt_we;
              wdata_q <= nxt_we ? nxt_wdata : '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
